// File: rtl/srt_quotient_assembler_if.sv
// srt_quotient_assembler_if
//   Bundles the start/done handshake, the digit stream, the residual and the
//   final results of the SRT quotient assembler.
//   Parameter NSTEP sets the quotient width QW = 4*NSTEP.
//   Signals:
//     start, dig_valid, qj, qjn   - division start and per-cycle digit pair
//     rem_sum, rem_carry          - carry-save residual, taken with the last pair
//     divisor                     - divisor, taken at start
//     quot, rem                   - final quotient and corrected remainder
//     busy, done                  - status and single-cycle completion pulse
//     err                         - sticky illegal-digit flag (SRT_DIGIT_CHECK_EN only)
//   Modports: master drives the inputs, slave is the assembler.
//   Optional feature macro: SRT_DIGIT_CHECK_EN
interface srt_quotient_assembler_if #(
    parameter int NSTEP = 2
);
    localparam int QW = 4 * NSTEP;

    logic          start;
    logic          dig_valid;
    logic [3:0]    qj;
    logic [3:0]    qjn;
    logic [10:0]   rem_sum;
    logic [10:0]   rem_carry;
    logic [7:0]    divisor;
    logic [QW-1:0] quot;
    logic [10:0]   rem;
    logic          busy;
    logic          done;
`ifdef SRT_DIGIT_CHECK_EN
    logic          err;

    modport master (
        output start, dig_valid, qj, qjn, rem_sum, rem_carry, divisor,
        input  quot, rem, busy, done, err
    );
    modport slave (
        input  start, dig_valid, qj, qjn, rem_sum, rem_carry, divisor,
        output quot, rem, busy, done, err
    );
`else
    modport master (
        output start, dig_valid, qj, qjn, rem_sum, rem_carry, divisor,
        input  quot, rem, busy, done
    );
    modport slave (
        input  start, dig_valid, qj, qjn, rem_sum, rem_carry, divisor,
        output quot, rem, busy, done
    );
`endif
endinterface

// File: rtl/srt_quotient_assembler.sv
// srt_quotient_assembler
//   Back end of the radix-16 SRT divider. Builds the binary quotient from
//   pairs of signed radix-4 digits by on-the-fly conversion, resolves the
//   carry-save residual and applies the negative-remainder correction.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous active-high reset
//     bus   - srt_quotient_assembler_if.slave (handshake, digits, results)
//   Optional feature macro: SRT_DIGIT_CHECK_EN adds the sticky err flag that
//   reports multi-hot digit codes.
//
//   state | meaning
//   IDLE  | waiting for start
//   ACCUM | converting digit pairs, NSTEP pairs expected
//   FINAL | resolve residual, pick Q or QM, correct remainder
//   DONE  | one-cycle done pulse, busy low
module srt_quotient_assembler #(
    parameter int NSTEP = 2
) (
    input logic                     clk,
    input logic                     reset,
    srt_quotient_assembler_if.slave bus
);
    localparam int QW = 4 * NSTEP;
    localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

    state_t        state, state_nxt;
    logic [QW-1:0] q_r, qm_r, q_nxt, qm_nxt;
    logic [QW-1:0] quot_r, quot_nxt;
    logic [10:0]   rem_r, rem_nxt;
    logic [10:0]   rs_r, rc_r, rs_nxt, rc_nxt;
    logic [7:0]    dv_r, dv_nxt;
    logic [CW-1:0] cnt_r, cnt_nxt;
    logic          busy_r, busy_nxt, done_r, done_nxt;
    logic [10:0]   w;
    logic [2*QW-1:0] step1, step2;

    // Q tracks the quotient, QM tracks quotient-1; a negative digit borrows
    // from QM so no carry propagation is ever needed.
    function automatic logic [2*QW-1:0] conv_step(input logic [QW-1:0] q,
                                                  input logic [QW-1:0] qm,
                                                  input logic [3:0]    dig);
        logic [QW-1:0] q4, qm4, mag;
        logic          pos, neg;
        q4  = q << 2;
        qm4 = qm << 2;
        pos = 1'b0;
        neg = 1'b0;
        mag = '0;
        // highest set bit wins so multi-hot codes still decode deterministically
        if (dig[3]) begin
            pos = 1'b1; mag = QW'(2);
        end else if (dig[2]) begin
            pos = 1'b1; mag = QW'(1);
        end else if (dig[1]) begin
            neg = 1'b1; mag = QW'(1);
        end else if (dig[0]) begin
            neg = 1'b1; mag = QW'(2);
        end
        if (pos)
            conv_step = {q4 + mag, q4 + mag - QW'(1)};
        else if (neg)
            conv_step = {qm4 + QW'(4) - mag, qm4 + QW'(3) - mag};
        else
            conv_step = {q4, qm4 + QW'(3)};
    endfunction

    assign w     = rs_r + rc_r;
    assign step1 = conv_step(q_r, qm_r, bus.qj);
    assign step2 = conv_step(step1[2*QW-1:QW], step1[QW-1:0], bus.qjn);

`ifdef SRT_DIGIT_CHECK_EN
    logic err_r, err_nxt;
    logic multi_hot;
    assign multi_hot = ((bus.qj  & (bus.qj  - 4'd1)) != 4'd0) ||
                       ((bus.qjn & (bus.qjn - 4'd1)) != 4'd0);
    assign bus.err   = err_r;
`endif

    always_comb begin
        state_nxt = state;
        q_nxt     = q_r;
        qm_nxt    = qm_r;
        quot_nxt  = quot_r;
        rem_nxt   = rem_r;
        rs_nxt    = rs_r;
        rc_nxt    = rc_r;
        dv_nxt    = dv_r;
        cnt_nxt   = cnt_r;
        busy_nxt  = busy_r;
        done_nxt  = 1'b0;
`ifdef SRT_DIGIT_CHECK_EN
        err_nxt   = err_r;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    q_nxt     = '0;
                    qm_nxt    = '1;
                    cnt_nxt   = '0;
                    dv_nxt    = bus.divisor;
                    busy_nxt  = 1'b1;
                    state_nxt = ACCUM;
`ifdef SRT_DIGIT_CHECK_EN
                    err_nxt   = 1'b0;
`endif
                end
            end
            ACCUM: begin
                if (bus.dig_valid) begin
                    q_nxt  = step2[2*QW-1:QW];
                    qm_nxt = step2[QW-1:0];
`ifdef SRT_DIGIT_CHECK_EN
                    err_nxt = err_r | multi_hot;
`endif
                    if (cnt_r == LAST) begin
                        rs_nxt    = bus.rem_sum;
                        rc_nxt    = bus.rem_carry;
                        state_nxt = FINAL;
                    end else begin
                        cnt_nxt = cnt_r + CW'(1);
                    end
                end
            end
            FINAL: begin
                // w == 0 is non-negative: only the sign bit triggers correction
                if (w[10]) begin
                    quot_nxt = qm_r;
                    rem_nxt  = w + {3'b000, dv_r};
                end else begin
                    quot_nxt = q_r;
                    rem_nxt  = w;
                end
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            q_r    <= '0;
            qm_r   <= '1;
            quot_r <= '0;
            rem_r  <= '0;
            rs_r   <= '0;
            rc_r   <= '0;
            dv_r   <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            q_r    <= q_nxt;
            qm_r   <= qm_nxt;
            quot_r <= quot_nxt;
            rem_r  <= rem_nxt;
            rs_r   <= rs_nxt;
            rc_r   <= rc_nxt;
            dv_r   <= dv_nxt;
            cnt_r  <= cnt_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
        end
    end

`ifdef SRT_DIGIT_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_r <= 1'b0;
        else       err_r <= err_nxt;
    end
`endif

    assign bus.quot = quot_r;
    assign bus.rem  = rem_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_srt_quotient_assembler.sv
// tb_srt_quotient_assembler
//   Scoreboard bench: each division pushes its expected quot/rem when the
//   digits are driven; a monitor pops and compares on every done pulse.
module tb_srt_quotient_assembler;
    localparam int NSTEP = 2;
    localparam int ND    = 2 * NSTEP;

    typedef struct {
        logic [7:0]  q;
        logic [10:0] r;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb [$];

    srt_quotient_assembler_if #(.NSTEP(NSTEP)) bus ();

    srt_quotient_assembler #(.NSTEP(NSTEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int dval(input logic [3:0] code);
        if (code[3])      return 2;
        else if (code[2]) return 1;
        else if (code[1]) return -1;
        else if (code[0]) return -2;
        return 0;
    endfunction

    function automatic logic [3:0] enc(input int d);
        case (d)
            2:       return 4'b1000;
            1:       return 4'b0100;
            -1:      return 4'b0010;
            -2:      return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            check("sb_nonempty_at_done", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("quot", 32'(bus.quot), 32'(e.q));
                check("rem",  32'(bus.rem),  32'(e.r));
            end
        end
    end

    task automatic run_div(input logic [3:0] c [ND], input int gaps [NSTEP],
                           input logic [10:0] rs, input logic [10:0] rc,
                           input logic [7:0] dv, input bit start_at_done);
        int          v, ts, tot_gap;
        logic [10:0] w;
        exp_t        e;
        bit          got, exp_err;
        v = 0;
        exp_err = 1'b0;
        for (int i = 0; i < ND; i++) begin
            v = v * 4 + dval(c[i]);
            if ((c[i] & (c[i] - 4'd1)) != 4'd0) exp_err = 1'b1;
        end
        w = rs + rc;
        if (w[10]) begin
            e.q = 8'(v - 1);
            e.r = w + {3'b000, dv};
        end else begin
            e.q = 8'(v);
            e.r = w;
        end

        @(posedge clk); #1;
        ts = cyc;
        bus.start   = 1'b1;
        bus.divisor = dv;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.divisor = 8'h00;
        check("busy_after_start", 32'(bus.busy), 1);
`ifdef SRT_DIGIT_CHECK_EN
        check("err_clear_on_start", 32'(bus.err), 0);
`endif
        tot_gap = 0;
        for (int p = 0; p < NSTEP; p++) begin
            repeat (gaps[p]) @(posedge clk);
            if (gaps[p] > 0) #1;
            tot_gap += gaps[p];
            bus.dig_valid = 1'b1;
            bus.qj  = c[2*p];
            bus.qjn = c[2*p+1];
            if (p == NSTEP - 1) begin
                bus.rem_sum   = rs;
                bus.rem_carry = rc;
                sb.push_back(e);
            end
            @(posedge clk); #1;
            bus.dig_valid = 1'b0;
            bus.qj  = 4'b0000;
            bus.qjn = 4'b0000;
            bus.rem_sum   = 11'h000;
            bus.rem_carry = 11'h000;
        end

        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) got = 1'b1;
        end
        check("done_seen", 32'(got), 1);
        if (got) begin
            check("done_latency", 32'(cyc - ts), 32'(NSTEP + 2 + tot_gap));
            check("busy_low_at_done", 32'(bus.busy), 0);
`ifdef SRT_DIGIT_CHECK_EN
            check("err_at_done", 32'(bus.err), 32'(exp_err));
`endif
            if (start_at_done) begin
                bus.start   = 1'b1;
                bus.divisor = 8'hFF;
                @(posedge clk); #1;
                bus.start   = 1'b0;
                bus.divisor = 8'h00;
                @(negedge clk);
                check("start_at_done_ignored", 32'(bus.busy), 0);
            end else begin
                @(negedge clk);
            end
            check("done_single_cycle", 32'(bus.done), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] c [ND];
        int         g [NSTEP];
        int         seen_done;

        n_checks = 0;
        n_fail   = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.dig_valid = 1'b0;
        bus.qj        = 4'b0000;
        bus.qjn       = 4'b0000;
        bus.rem_sum   = 11'h000;
        bus.rem_carry = 11'h000;
        bus.divisor   = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_quot", 32'(bus.quot), 0);
        check("rst_rem",  32'(bus.rem),  0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
`ifdef SRT_DIGIT_CHECK_EN
        check("rst_err",  32'(bus.err),  0);
`endif
        reset = 1'b0;

        // (+1,+2),(-1,0), positive residual
        c = '{enc(1), enc(2), enc(-1), enc(0)};
        g = '{0, 0};
        run_div(c, g, 11'h005, 11'h002, 8'h09, 1'b0);

        // same digits, negative residual -> QM and corrected remainder
        run_div(c, g, 11'h7FE, 11'h000, 8'h09, 1'b1);

        // (-1,0),(0,0), zero residual
        c = '{enc(-1), enc(0), enc(0), enc(0)};
        run_div(c, g, 11'h000, 11'h000, 8'h05, 1'b0);

        // all zero digits with a 3-cycle gap between pairs
        c = '{enc(0), enc(0), enc(0), enc(0)};
        g = '{0, 3};
        run_div(c, g, 11'h001, 11'h000, 8'h03, 1'b0);

        // reset in the middle of a division
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.divisor = 8'h11;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.dig_valid = 1'b1;
        bus.qj        = enc(2);
        bus.qjn       = enc(1);
        @(posedge clk); #3;
        bus.dig_valid = 1'b0;
        bus.qj        = 4'b0000;
        bus.qjn       = 4'b0000;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_quot", 32'(bus.quot), 0);
        check("midrst_rem",  32'(bus.rem),  0);
        @(posedge clk); #3;
        reset = 1'b0;
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done++;
        end
        check("no_done_after_reset", 32'(seen_done), 0);

        // fresh division after reset
        c = '{enc(2), enc(-2), enc(1), enc(-1)};
        g = '{1, 0};
        run_div(c, g, 11'h0F0, 11'h00F, 8'h21, 1'b0);

`ifdef SRT_DIGIT_CHECK_EN
        // multi-hot 0110 decodes as +1 and sets the sticky err
        c = '{4'b0110, enc(0), enc(0), enc(0)};
        g = '{0, 0};
        run_div(c, g, 11'h002, 11'h000, 8'h07, 1'b0);
        // next start clears err (checked inside run_div)
        c = '{enc(1), enc(1), enc(1), enc(1)};
        run_div(c, g, 11'h004, 11'h7F0, 8'h0C, 1'b0);
`endif

        // random legal digit streams
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < ND; i++) c[i] = enc(int'($urandom_range(4)) - 2);
            for (int p = 0; p < NSTEP; p++) g[p] = int'($urandom_range(2));
            run_div(c, g, 11'($urandom), 11'($urandom), 8'($urandom_range(255, 1)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/srt_quotient_assembler.md
# srt_quotient_assembler

Back end of the radix-16 SRT divider datapath. It accepts the per-cycle pair of signed radix-4 quotient digits and the final carry-save residual from the divider step, and builds the binary quotient by on-the-fly conversion. It then resolves the residual, applies the negative-remainder correction, and presents the final quotient and remainder with a start/done handshake. It sits directly downstream of the divider step and is sequenced by the same `clk`.

## Interface
- `NSTEP`, default 2: number of digit-pair cycles per division; quotient width QW = 4*NSTEP.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: begin a division; sampled only in IDLE.
- `dig_valid` input 1: the `qj`/`qjn` pair is valid this cycle.
- `qj` input 4: first, more significant digit, one-hot: [3]=+2, [2]=+1, [1]=-1, [0]=-2, 0000=0.
- `qjn` input 4: second digit, same encoding.
- `rem_sum` input 11: residual sum; sampled with the last pair.
- `rem_carry` input 11: residual carry; sampled with the last pair.
- `divisor` input 8: divisor, used for the correction; sampled at `start`.
- `quot` output QW: final quotient, two's complement modulo 2^QW.
- `rem` output 11: corrected remainder.
- `busy` output 1: high from the `start` acceptance until `done`.
- `done` output 1: single-cycle pulse when `quot`/`rem` update.
- `err` output 1: illegal digit flag; present only with the macro.

## Operation
- States are IDLE, ACCUM, FINAL and DONE.
- IDLE:
  - `start`=1 loads Q=0, QM=all ones (-1), count=0, latches `divisor`, sets `busy`=1, and moves to ACCUM.
- ACCUM:
  - Each cycle with `dig_valid`=1 applies two conversion steps, `qj` first, then `qjn`.
  - For digit q:
    - q>0: Q'=4Q+q, QM'=4Q+q-1.
    - q=0: Q'=4Q, QM'=4QM+3.
    - q<0: Q'=4QM+4+q, QM'=4QM+3+q.
  - All arithmetic is modulo 2^QW.
  - When the pair taken is the NSTEP-th, `rem_sum`/`rem_carry` are also registered and the state moves to FINAL.
  - `dig_valid`=0 holds Q, QM and count.
- FINAL:
  - w = rem_sum + rem_carry, 11 bits, carry out discarded.
  - If w[10]=1: `quot`=QM and `rem`=w+{3'b000,divisor}.
  - Otherwise: `quot`=Q and `rem`=w.
  - Both are registered and the state moves to DONE.
- DONE:
  - `done`=1 and `busy`=0 for one cycle, then back to IDLE.
- Digit decode uses priority: the highest set bit wins, so illegal multi-hot codes still resolve deterministically.
- `start` outside IDLE is ignored.
- `quot`/`rem` hold their values until the next FINAL.
- Reset values: `quot`=0, `rem`=0, `busy`=0, `done`=0, `err`=0, state IDLE, Q=0, QM=all ones, count=0.

## Timing
- `start` is accepted at edge t0. Digit pairs can be accepted from edge t0+1 onward.
- The last pair is accepted at edge tk. `quot`/`rem` are registered at tk+1, and `done` is high during the cycle after tk+1.
- Minimum latency from `start` to `done` is NSTEP+2 edges.
- A new `start` is accepted in the cycle after `done`. A `start` asserted in the same cycle as `done` is ignored.
- `dig_valid` gaps stretch ACCUM with no loss of state.
- Reset asserted mid-operation clears everything asynchronously: state returns to IDLE and `done` is not produced.
- An edge case with w=0 counts as non-negative, so no correction is applied.

## Configuration
- `SRT_DIGIT_CHECK_EN` defined:
  - `err` is a sticky flag. It sets when any accepted `qj` or `qjn` has more than one bit set.
  - It clears on `start` acceptance and on reset.
  - Conversion still uses the priority decode.
- `SRT_DIGIT_CHECK_EN` not defined:
  - The `err` port is absent and there is no check logic.

## Test plan
- Pairs (+1,+2),(-1,0); `rem_sum`=0x005, `rem_carry`=0x002 -> `quot`=0x5C, `rem`=0x007, `done` one cycle at start+4.
- Same digits; `rem_sum`=0x7FE, `rem_carry`=0x000, `divisor`=0x09 -> `quot`=0x5B, `rem`=0x007.
- Pairs (-1,0),(0,0); residual 0 -> `quot`=0xC0, `rem`=0x000, no correction.
- Pairs (0,0),(0,0) with `dig_valid` low for 3 cycles between them; residual 0x001 -> `quot`=0x00, `done` at start+7.
- `reset` pulsed after the first pair -> `busy`=0, `quot`=0, `rem`=0, no `done`. A fresh division afterwards is correct.
- With `SRT_DIGIT_CHECK_EN`: `qj`=0110 -> `err`=1 and decoded as +1. `err` stays high through `done` and clears on the next `start`.
